// File: rtl/dual_issue_unit.sv
// dual_issue_unit
// In-order dual-issue stage. Buffers one decoded instruction pair, tracks in-flight register
// writes in a 128-entry, 3-bit latency scoreboard, and dispatches at most one instruction to the
// even pipe and one to the odd pipe per cycle through registered issue outputs.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   in_valid_i / in_ready_o       pair handshake (accepted when both high at a rising edge)
//   inK_*_i (K = 0, 1)            decoded instruction K; inst0 is older than inst1
//   branch_taken_i                flush request from the odd pipe
//   ep_opcode_o, *_ep_*_o         even-pipe issue registers (NOP when idle)
//   op_opcode_o, *_op_*_o         odd-pipe issue registers (LNOP when idle, no rc)
//   stall_o                       a buffered instruction was held this cycle
//
// Opcode encoding: 8 bits, 8'h00 = NOP (even idle), 8'h01 = LNOP (odd idle).
module dual_issue_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        in0_pipe_i,
    input  logic [7:0]  in0_opcode_i,
    input  logic [6:0]  in0_rt_i,
    input  logic [6:0]  in0_ra_i,
    input  logic [6:0]  in0_rb_i,
    input  logic [6:0]  in0_rc_i,
    input  logic        in0_use_ra_i,
    input  logic        in0_use_rb_i,
    input  logic        in0_use_rc_i,
    input  logic        in0_wr_rt_i,
    input  logic [2:0]  in0_lat_i,
    input  logic [6:0]  in0_i7_i,
    input  logic [9:0]  in0_i10_i,
    input  logic [15:0] in0_i16_i,
    input  logic [17:0] in0_i18_i,
    input  logic        in1_pipe_i,
    input  logic [7:0]  in1_opcode_i,
    input  logic [6:0]  in1_rt_i,
    input  logic [6:0]  in1_ra_i,
    input  logic [6:0]  in1_rb_i,
    input  logic [6:0]  in1_rc_i,
    input  logic        in1_use_ra_i,
    input  logic        in1_use_rb_i,
    input  logic        in1_use_rc_i,
    input  logic        in1_wr_rt_i,
    input  logic [2:0]  in1_lat_i,
    input  logic [6:0]  in1_i7_i,
    input  logic [9:0]  in1_i10_i,
    input  logic [15:0] in1_i16_i,
    input  logic [17:0] in1_i18_i,
    input  logic        branch_taken_i,
    output logic [7:0]  ep_opcode_o,
    output logic [6:0]  ra_ep_address_o,
    output logic [6:0]  rb_ep_address_o,
    output logic [6:0]  rc_ep_address_o,
    output logic [6:0]  rt_ep_address_o,
    output logic [6:0]  i7_ep_o,
    output logic [9:0]  i10_ep_o,
    output logic [15:0] i16_ep_o,
    output logic [17:0] i18_ep_o,
    output logic [7:0]  op_opcode_o,
    output logic [6:0]  ra_op_address_o,
    output logic [6:0]  rb_op_address_o,
    output logic [6:0]  rt_op_address_o,
    output logic [6:0]  i7_op_o,
    output logic [9:0]  i10_op_o,
    output logic [15:0] i16_op_o,
    output logic [17:0] i18_op_o,
    output logic        stall_o
);

    localparam logic [7:0] OpNop  = 8'h00;
    localparam logic [7:0] OpLnop = 8'h01;

    typedef struct packed {
        logic        pipe;
        logic [7:0]  opcode;
        logic [6:0]  rt;
        logic [6:0]  ra;
        logic [6:0]  rb;
        logic [6:0]  rc;
        logic        use_ra;
        logic        use_rb;
        logic        use_rc;
        logic        wr_rt;
        logic [2:0]  lat;
        logic [6:0]  i7;
        logic [9:0]  i10;
        logic [15:0] i16;
        logic [17:0] i18;
    } inst_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [6:0]  rt;
        logic [6:0]  ra;
        logic [6:0]  rb;
        logic [6:0]  rc;
        logic [6:0]  i7;
        logic [9:0]  i10;
        logic [15:0] i16;
        logic [17:0] i18;
    } ep_issue_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [6:0]  rt;
        logic [6:0]  ra;
        logic [6:0]  rb;
        logic [6:0]  i7;
        logic [9:0]  i10;
        logic [15:0] i16;
        logic [17:0] i18;
    } op_issue_t;

    typedef enum logic [1:0] {StEmpty, StPair, StSecond} state_e;

    function automatic ep_issue_t to_ep(inst_t x);
        return '{opcode: x.opcode, rt: x.rt, ra: x.ra, rb: x.rb, rc: x.rc,
                 i7: x.i7, i10: x.i10, i16: x.i16, i18: x.i18};
    endfunction

    function automatic op_issue_t to_op(inst_t x);
        return '{opcode: x.opcode, rt: x.rt, ra: x.ra, rb: x.rb,
                 i7: x.i7, i10: x.i10, i16: x.i16, i18: x.i18};
    endfunction

    inst_t     in0, in1;
    inst_t     inst0_q, inst1_q;
    state_e    state_q, state_d;
    logic [2:0] sb_q [128];
    logic [2:0] sb_d [128];
    ep_issue_t ep_q, ep_d;
    op_issue_t op_q, op_d;

    logic rdy0, rdy1, raw, waw;
    logic issue0, issue1, accept;

    assign in0 = '{pipe: in0_pipe_i, opcode: in0_opcode_i, rt: in0_rt_i, ra: in0_ra_i,
                   rb: in0_rb_i, rc: in0_rc_i, use_ra: in0_use_ra_i, use_rb: in0_use_rb_i,
                   use_rc: in0_use_rc_i, wr_rt: in0_wr_rt_i, lat: in0_lat_i, i7: in0_i7_i,
                   i10: in0_i10_i, i16: in0_i16_i, i18: in0_i18_i};
    assign in1 = '{pipe: in1_pipe_i, opcode: in1_opcode_i, rt: in1_rt_i, ra: in1_ra_i,
                   rb: in1_rb_i, rc: in1_rc_i, use_ra: in1_use_ra_i, use_rb: in1_use_rb_i,
                   use_rc: in1_use_rc_i, wr_rt: in1_wr_rt_i, lat: in1_lat_i, i7: in1_i7_i,
                   i10: in1_i10_i, i16: in1_i16_i, i18: in1_i18_i};

    // A source is ready when unused or its scoreboard entry has drained to zero.
    assign rdy0 = (!inst0_q.use_ra || sb_q[inst0_q.ra] == 3'd0)
               && (!inst0_q.use_rb || sb_q[inst0_q.rb] == 3'd0)
               && (!inst0_q.use_rc || sb_q[inst0_q.rc] == 3'd0);
    assign rdy1 = (!inst1_q.use_ra || sb_q[inst1_q.ra] == 3'd0)
               && (!inst1_q.use_rb || sb_q[inst1_q.rb] == 3'd0)
               && (!inst1_q.use_rc || sb_q[inst1_q.rc] == 3'd0);

    // Intra-pair hazards: inst1 may not co-issue with an older writer of its sources or rt.
    assign raw = inst0_q.wr_rt
              && ((inst1_q.use_ra && inst1_q.ra == inst0_q.rt)
               || (inst1_q.use_rb && inst1_q.rb == inst0_q.rt)
               || (inst1_q.use_rc && inst1_q.rc == inst0_q.rt));
    assign waw = inst0_q.wr_rt && inst1_q.wr_rt && (inst0_q.rt == inst1_q.rt);

    always_comb begin
        issue0 = 1'b0;
        issue1 = 1'b0;
        unique case (state_q)
            StPair: begin
                issue0 = !branch_taken_i && rdy0;
                issue1 = issue0 && (inst0_q.pipe != inst1_q.pipe) && rdy1 && !raw && !waw;
            end
            StSecond: issue1 = !branch_taken_i && rdy1;
            default: ;
        endcase
    end

    // issue1 marks the last held instruction leaving in both PAIR and SECOND.
    assign in_ready_o = !branch_taken_i && (state_q == StEmpty || issue1);
    assign stall_o    = (state_q != StEmpty) && !branch_taken_i && !issue1;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        if (branch_taken_i) begin
            state_d = StEmpty;
        end else if (accept) begin
            state_d = StPair;
        end else begin
            unique case (state_q)
                StPair:   state_d = issue1 ? StEmpty : (issue0 ? StSecond : StPair);
                StSecond: state_d = issue1 ? StEmpty : StSecond;
                default:  state_d = StEmpty;
            endcase
        end
    end

    // Route issued instructions to their pipes; in PAIR the two pipes are known to differ.
    always_comb begin
        ep_d        = '0;
        ep_d.opcode = OpNop;
        op_d        = '0;
        op_d.opcode = OpLnop;
        if (issue0 && !inst0_q.pipe) begin
            ep_d = to_ep(inst0_q);
        end else if (issue1 && !inst1_q.pipe) begin
            ep_d = to_ep(inst1_q);
        end
        if (issue0 && inst0_q.pipe) begin
            op_d = to_op(inst0_q);
        end else if (issue1 && inst1_q.pipe) begin
            op_d = to_op(inst1_q);
        end
    end

    // Decrement every live entry; a new write latency overrides the decrement.
    always_comb begin
        for (int i = 0; i < 128; i++) begin
            sb_d[i] = (sb_q[i] != 3'd0) ? sb_q[i] - 3'd1 : 3'd0;
        end
        if (issue0 && inst0_q.wr_rt && inst0_q.lat != 3'd0) begin
            sb_d[inst0_q.rt] = inst0_q.lat;
        end
        if (issue1 && inst1_q.wr_rt && inst1_q.lat != 3'd0) begin
            sb_d[inst1_q.rt] = inst1_q.lat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StEmpty;
            inst0_q     <= '0;
            inst1_q     <= '0;
            ep_q        <= '0;
            ep_q.opcode <= OpNop;
            op_q        <= '0;
            op_q.opcode <= OpLnop;
            for (int i = 0; i < 128; i++) begin
                sb_q[i] <= 3'd0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                inst0_q <= in0;
                inst1_q <= in1;
            end
            ep_q <= ep_d;
            op_q <= op_d;
            for (int i = 0; i < 128; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    assign ep_opcode_o     = ep_q.opcode;
    assign rt_ep_address_o = ep_q.rt;
    assign ra_ep_address_o = ep_q.ra;
    assign rb_ep_address_o = ep_q.rb;
    assign rc_ep_address_o = ep_q.rc;
    assign i7_ep_o         = ep_q.i7;
    assign i10_ep_o        = ep_q.i10;
    assign i16_ep_o        = ep_q.i16;
    assign i18_ep_o        = ep_q.i18;

    assign op_opcode_o     = op_q.opcode;
    assign rt_op_address_o = op_q.rt;
    assign ra_op_address_o = op_q.ra;
    assign rb_op_address_o = op_q.rb;
    assign i7_op_o         = op_q.i7;
    assign i10_op_o        = op_q.i10;
    assign i16_op_o        = op_q.i16;
    assign i18_op_o        = op_q.i18;

endmodule

// File: tb/tb_dual_issue_unit.sv
// Testbench for dual_issue_unit: directed scenarios followed by randomized traffic, checked
// against a timestamp-based reference model. Expected issues are queued per pipe and a
// separate monitor pops and compares them whenever a pipe shows a non-idle opcode.
module tb_dual_issue_unit;

    localparam logic [7:0] NopOp  = 8'h00;
    localparam logic [7:0] LnopOp = 8'h01;

    typedef struct packed {
        logic        pipe;
        logic [7:0]  op;
        logic [6:0]  rt;
        logic [6:0]  ra;
        logic [6:0]  rb;
        logic [6:0]  rc;
        logic        ura;
        logic        urb;
        logic        urc;
        logic        wr;
        logic [2:0]  lat;
        logic [6:0]  i7;
        logic [9:0]  i10;
        logic [15:0] i16;
        logic [17:0] i18;
    } ins_t;

    typedef struct {
        int   stamp;
        ins_t ins;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic br = 1'b0;
    ins_t a_s = '0;
    ins_t b_s = '0;
    logic in_ready, stall;
    logic [7:0]  ep_op, op_op;
    logic [6:0]  ra_ep, rb_ep, rc_ep, rt_ep, i7_ep, ra_op, rb_op, rt_op, i7_op;
    logic [9:0]  i10_ep, i10_op;
    logic [15:0] i16_ep, i16_op;
    logic [17:0] i18_ep, i18_op;

    always #5 clk = ~clk;

    dual_issue_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in0_pipe_i(a_s.pipe), .in0_opcode_i(a_s.op), .in0_rt_i(a_s.rt), .in0_ra_i(a_s.ra),
        .in0_rb_i(a_s.rb), .in0_rc_i(a_s.rc), .in0_use_ra_i(a_s.ura), .in0_use_rb_i(a_s.urb),
        .in0_use_rc_i(a_s.urc), .in0_wr_rt_i(a_s.wr), .in0_lat_i(a_s.lat), .in0_i7_i(a_s.i7),
        .in0_i10_i(a_s.i10), .in0_i16_i(a_s.i16), .in0_i18_i(a_s.i18),
        .in1_pipe_i(b_s.pipe), .in1_opcode_i(b_s.op), .in1_rt_i(b_s.rt), .in1_ra_i(b_s.ra),
        .in1_rb_i(b_s.rb), .in1_rc_i(b_s.rc), .in1_use_ra_i(b_s.ura), .in1_use_rb_i(b_s.urb),
        .in1_use_rc_i(b_s.urc), .in1_wr_rt_i(b_s.wr), .in1_lat_i(b_s.lat), .in1_i7_i(b_s.i7),
        .in1_i10_i(b_s.i10), .in1_i16_i(b_s.i16), .in1_i18_i(b_s.i18),
        .branch_taken_i(br),
        .ep_opcode_o(ep_op), .ra_ep_address_o(ra_ep), .rb_ep_address_o(rb_ep),
        .rc_ep_address_o(rc_ep), .rt_ep_address_o(rt_ep), .i7_ep_o(i7_ep), .i10_ep_o(i10_ep),
        .i16_ep_o(i16_ep), .i18_ep_o(i18_ep),
        .op_opcode_o(op_op), .ra_op_address_o(ra_op), .rb_op_address_o(rb_op),
        .rt_op_address_o(rt_op), .i7_op_o(i7_op), .i10_op_o(i10_op), .i16_op_o(i16_op),
        .i18_op_o(i18_op),
        .stall_o(stall)
    );

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    // ready_at[r]: first decision cycle in which register r may be read.
    int   ready_at [128];
    ins_t held [$];
    exp_t ep_q [$];
    exp_t op_q [$];
    exp_t ep_e, op_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic src_ok(ins_t x);
        return (!x.ura || ready_at[x.ra] <= cyc) && (!x.urb || ready_at[x.rb] <= cyc)
            && (!x.urc || ready_at[x.rc] <= cyc);
    endfunction

    function automatic logic hazard(ins_t o, ins_t y);
        logic reads;
        reads = (y.ura && y.ra == o.rt) || (y.urb && y.rb == o.rt) || (y.urc && y.rc == o.rt);
        return o.wr && (reads || (y.wr && y.rt == o.rt));
    endfunction

    function automatic logic [86:0] pack(ins_t x, logic odd);
        return {x.op, x.rt, x.ra, x.rb, odd ? 7'd0 : x.rc, x.i7, x.i10, x.i16, x.i18};
    endfunction

    function automatic ins_t mk(logic pipe, logic [7:0] op, logic [6:0] rt, logic [6:0] ra,
                                logic [6:0] rb, logic ura, logic urb, logic wr,
                                logic [2:0] lat);
        ins_t x;
        x = '{pipe: pipe, op: op, rt: rt, ra: ra, rb: rb, rc: 7'd0, ura: ura, urb: urb,
              urc: 1'b0, wr: wr, lat: lat, i7: 7'($urandom), i10: 10'($urandom),
              i16: 16'($urandom), i18: 18'($urandom)};
        return x;
    endfunction

    function automatic ins_t rnd();
        ins_t x;
        x = '{pipe: 1'($urandom), op: 8'($urandom_range(2, 255)),
              rt: 7'($urandom_range(0, 7)), ra: 7'($urandom_range(0, 7)),
              rb: 7'($urandom_range(0, 7)), rc: 7'($urandom_range(0, 7)),
              ura: 1'($urandom), urb: 1'($urandom), urc: 1'($urandom), wr: 1'($urandom),
              lat: 3'($urandom), i7: 7'($urandom), i10: 10'($urandom),
              i16: 16'($urandom), i18: 18'($urandom)};
        return x;
    endfunction

    task automatic emit(input ins_t x);
        exp_t e;
        e.stamp = cyc + 1;
        e.ins   = x;
        if (x.pipe) op_q.push_back(e);
        else        ep_q.push_back(e);
    endtask

    // One decision cycle of the reference model, evaluated with this cycle's inputs applied.
    task automatic model_step();
        int   n_iss, sb_bad, e;
        logic all_done, exp_ready, exp_stall;
        sb_bad = 0;
        for (int r = 0; r < 128; r++) begin
            e = ready_at[r] - cyc;
            if (e < 0) e = 0;
            if (int'(dut.sb_q[r]) != e) sb_bad++;
        end
        check("scoreboard", 128'(sb_bad), 128'd0);
        n_iss = 0;
        if (!br && held.size() == 2) begin
            if (src_ok(held[0])) begin
                n_iss = 1;
                if (held[0].pipe != held[1].pipe && src_ok(held[1])
                    && !hazard(held[0], held[1])) n_iss = 2;
            end
        end else if (!br && held.size() == 1) begin
            if (src_ok(held[0])) n_iss = 1;
        end
        all_done  = (n_iss == held.size());
        exp_ready = !br && all_done;
        exp_stall = held.size() > 0 && !br && !all_done;
        check("in_ready", 128'(in_ready), 128'(exp_ready));
        check("stall", 128'(stall), 128'(exp_stall));
        for (int i = 0; i < n_iss; i++) emit(held[i]);
        for (int i = 0; i < n_iss; i++) begin
            if (held[i].wr && held[i].lat != 3'd0) ready_at[held[i].rt] = cyc + 1 + held[i].lat;
        end
        for (int i = 0; i < n_iss; i++) void'(held.pop_front());
        if (br) begin
            held.delete();
        end else if (in_valid && exp_ready) begin
            held.delete();
            held.push_back(a_s);
            held.push_back(b_s);
        end
    endtask

    task automatic do_cycle(input logic v, input ins_t a, input ins_t b, input logic bt);
        @(negedge clk);
        in_valid = v;
        a_s      = a;
        b_s      = b;
        br       = bt;
        #1;
        model_step();
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        int sb_bad;
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        br       = 1'b0;
        #1;
        check("rst_ep_opcode", 128'(ep_op), 128'(NopOp));
        check("rst_op_opcode", 128'(op_op), 128'(LnopOp));
        check("rst_ep_fields", {ra_ep, rb_ep, rc_ep, rt_ep, i7_ep, i10_ep, i16_ep, i18_ep}, '0);
        check("rst_op_fields", {ra_op, rb_op, rt_op, i7_op, i10_op, i16_op, i18_op}, '0);
        check("rst_stall", 128'(stall), 128'd0);
        sb_bad = 0;
        for (int r = 0; r < 128; r++) if (dut.sb_q[r] != 3'd0) sb_bad++;
        check("rst_scoreboard", 128'(sb_bad), 128'd0);
        held.delete();
        ep_q.delete();
        op_q.delete();
        for (int r = 0; r < 128; r++) ready_at[r] = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
    endtask

    // Monitor: outputs loaded at edge cyc are compared against issues stamped cyc.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ep_op != NopOp) begin
                if (ep_q.size() == 0) begin
                    check("ep_spurious", 128'(ep_op), 128'(NopOp));
                end else begin
                    ep_e = ep_q.pop_front();
                    check("ep_time", 128'(cyc), 128'(ep_e.stamp));
                    check("ep_fields", {ep_op, rt_ep, ra_ep, rb_ep, rc_ep, i7_ep, i10_ep,
                                        i16_ep, i18_ep}, 128'(pack(ep_e.ins, 1'b0)));
                end
            end else begin
                check("ep_idle_fields", {ra_ep, rb_ep, rc_ep, rt_ep, i7_ep, i10_ep, i16_ep,
                                         i18_ep}, '0);
                if (ep_q.size() != 0 && ep_q[0].stamp <= cyc) begin
                    ep_e = ep_q.pop_front();
                    check("ep_missing", 128'(ep_op), 128'(ep_e.ins.op));
                end
            end
            if (op_op != LnopOp) begin
                if (op_q.size() == 0) begin
                    check("op_spurious", 128'(op_op), 128'(LnopOp));
                end else begin
                    op_e = op_q.pop_front();
                    check("op_time", 128'(cyc), 128'(op_e.stamp));
                    check("op_fields", {op_op, rt_op, ra_op, rb_op, 7'd0, i7_op, i10_op,
                                        i16_op, i18_op}, 128'(pack(op_e.ins, 1'b1)));
                end
            end else begin
                check("op_idle_fields", {ra_op, rb_op, rt_op, i7_op, i10_op, i16_op, i18_op},
                      '0);
                if (op_q.size() != 0 && op_q[0].stamp <= cyc) begin
                    op_e = op_q.pop_front();
                    check("op_missing", 128'(op_op), 128'(op_e.ins.op));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ins_t a, b;
        for (int r = 0; r < 128; r++) ready_at[r] = 0;
        do_reset();
        idle(2);

        // Independent even/odd pair: dual issue in the first decision cycle.
        a = mk(1'b0, 8'h10, 7'd3, 7'd1, 7'd2, 1'b1, 1'b1, 1'b1, 3'd2);
        b = mk(1'b1, 8'h20, 7'd4, 7'd9, 7'd0, 1'b1, 1'b0, 1'b1, 3'd6);
        do_cycle(1'b1, a, b, 1'b0);
        idle(9);

        // Both even: serialized over two edges.
        a = mk(1'b0, 8'h11, 7'd10, 7'd11, 7'd0, 1'b1, 1'b0, 1'b1, 3'd1);
        b = mk(1'b0, 8'h12, 7'd12, 7'd13, 7'd0, 1'b1, 1'b0, 1'b1, 3'd1);
        do_cycle(1'b1, a, b, 1'b0);
        idle(4);

        // RAW through r5 with latency 6.
        a = mk(1'b0, 8'h13, 7'd5, 7'd1, 7'd2, 1'b1, 1'b1, 1'b1, 3'd6);
        b = mk(1'b1, 8'h14, 7'd6, 7'd5, 7'd0, 1'b1, 1'b0, 1'b1, 3'd1);
        do_cycle(1'b1, a, b, 1'b0);
        idle(10);

        // Flush while inst1 waits in SECOND.
        a = mk(1'b0, 8'h15, 7'd5, 7'd1, 7'd2, 1'b1, 1'b1, 1'b1, 3'd6);
        b = mk(1'b1, 8'h16, 7'd6, 7'd5, 7'd0, 1'b1, 1'b0, 1'b1, 3'd1);
        do_cycle(1'b1, a, b, 1'b0);
        do_cycle(1'b0, '0, '0, 1'b0);
        do_cycle(1'b1, a, b, 1'b1);
        idle(8);

        // Reset while r7 is pending and inst1 is held, then a reader of r7.
        a = mk(1'b0, 8'h17, 7'd7, 7'd1, 7'd0, 1'b1, 1'b0, 1'b1, 3'd5);
        b = mk(1'b1, 8'h18, 7'd8, 7'd7, 7'd0, 1'b1, 1'b0, 1'b1, 3'd1);
        do_cycle(1'b1, a, b, 1'b0);
        do_cycle(1'b0, '0, '0, 1'b0);
        do_reset();
        a = mk(1'b1, 8'h19, 7'd9, 7'd7, 7'd0, 1'b1, 1'b0, 1'b1, 3'd2);
        b = mk(1'b0, 8'h1a, 7'd11, 7'd12, 7'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        do_cycle(1'b1, a, b, 1'b0);
        idle(4);

        // Latency-0 writer followed by a reader in the other pipe.
        a = mk(1'b0, 8'h1b, 7'd20, 7'd1, 7'd0, 1'b1, 1'b0, 1'b1, 3'd0);
        b = mk(1'b1, 8'h1c, 7'd21, 7'd20, 7'd0, 1'b1, 1'b0, 1'b1, 3'd0);
        do_cycle(1'b1, a, b, 1'b0);
        idle(4);

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            do_cycle(1'($urandom_range(0, 9) < 7), rnd(), rnd(), 1'($urandom_range(0, 19) == 0));
        end
        idle(12);
        check("ep_drain", 128'(ep_q.size()), 128'd0);
        check("op_drain", 128'(op_q.size()), 128'd0);
        check("held_drain", 128'(held.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
